ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter; the send side of the keyboard link whose receive side is Ps2Controller.
//  Sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xFF reset) using the PS/2 host-request sequence.
//  Drives the open-collector lines through low-enables: top level does assign ps2_clk = clk_oe ? 1'b0 : 1'bz.
//  Raises rx_inhibit so Ps2Controller ignores line activity while this block owns the bus.
// PARAMETERS
//  INHIBIT_CYCLES  10000      clocks ps2_clk is held low before the request (100 us @ 100 MHz)
//  TIMEOUT_CYCLES  1500000    max clocks from releasing clock to the ack edge (15 ms)
//  FILTER_LEN      8          consecutive equal samples needed to accept a new ps2 line level
// PORTS
//  clk          in   1  system clock, single domain
//  reset        in   1  synchronous reset, active-low (0 = reset)
//  tx_valid     in   1  request to send tx_data
//  tx_data      in   8  command byte
//  tx_ready     out  1  1 = idle; a byte is accepted when tx_valid && tx_ready
//  ps2_clk_i    in   1  raw ps2_clk pin level (async)
//  ps2_data_i   in   1  raw ps2_data pin level (async)
//  clk_oe       out  1  1 = pull ps2_clk low
//  data_oe      out  1  1 = pull ps2_data low
//  rx_inhibit   out  1  1 = frame owned by host; Ps2Controller must not latch
//  done         out  1  one-cycle pulse when a transfer ends (success or error)
//  ack_err      out  1  valid with done: device did not pull data low on edge 11
//  timeout_err  out  1  valid with done: TIMEOUT_CYCLES expired
// BEHAVIOUR
//  Reset (reset==0 at posedge): state IDLE. clk_oe, data_oe, rx_inhibit, done, ack_err, timeout_err and tx_ready are all 0.
//    tx_ready goes to 1 on the first cycle after reset is released. Reset mid-transfer releases both lines on the next edge.
//  Inputs: 2-flop sync, then filter (level changes only after FILTER_LEN equal samples); fall = filtered clk 1->0.
//  FSM:
//   IDLE     tx_ready=1. On accept, latch tx_data, compute odd parity (~^tx_data), set rx_inhibit=1, go to INHIBIT.
//   INHIBIT  clk_oe=1 for INHIBIT_CYCLES. On the last cycle, set data_oe=1 (start bit) and go to REQ.
//   REQ      clk_oe=0, data_oe=1. Start timeout counter. Falling edge 1 drives D0, then go to SEND.
//   SEND     Falling edges 2..8 drive D1..D7 (LSB first). Edge 9 drives parity. Edge 10 releases data (stop bit), go to ACK.
//            Data bits are driven as data_oe = ~bit.
//   ACK      Falling edge 11: sample filtered data; ack_err = (data==1). Go to WAIT_IDLE.
//   WAIT_IDLE Both filtered lines high -> pulse done with flags, drop rx_inhibit, go to IDLE.
//  Timeout: counter runs from entry to REQ until edge 11. On expiry from REQ/SEND/ACK:
//    clk_oe=data_oe=0; done=1, timeout_err=1, ack_err=0; rx_inhibit=0; go to IDLE.
//  Flags hold their value until the next accept, then clear.
//  tx_valid while busy is ignored (no queue); the caller retries after done.
//  Extra falling edges in WAIT_IDLE are ignored. A filtered glitch shorter than FILTER_LEN never counts as an edge.
//  Latency: accept -> clk_oe=1 on the next cycle. done follows line idle by 1 cycle.
// STRUCTURE
//  ps2_pkg: state enum {IDLE,INHIBIT,REQ,SEND,ACK,WAIT_IDLE}.
//    Constants PS2_CMD_SET_LEDS=8'hED, PS2_CMD_RESET=8'hFF, PS2_RESP_ACK=8'hFA, PS2_FRAME_EDGES=11.
//  Sub-module ps2_line_filter (sync + FILTER_LEN debounce + fall/rise strobes), instantiated for clk and data.
//  Main FSM, 4-bit edge counter, shift register and timeout counter live in ps2_host_tx.
// TESTING (bench sets INHIBIT_CYCLES=20, TIMEOUT_CYCLES=5000, FILTER_LEN=4; device model clocks with a 400-cycle period)
//  T1 tx_data=8'hED, device acks -> bits seen on rising edges: start 0, 1,0,1,1,0,1,1,1, parity 1, stop 1.
//     Result: done=1, ack_err=0, timeout_err=0.
//  T2 tx_data=8'h07 -> parity bit 0. clk_oe high for exactly 20 cycles. data_oe rises on the last inhibit cycle.
//  T3 device leaves data high at edge 11 -> done=1, ack_err=1. rx_inhibit drops the same cycle as done.
//  T4 device never clocks -> after 5000 cycles in REQ: done=1, timeout_err=1, clk_oe=data_oe=0, tx_ready=1 next cycle.
//  T5 reset=0 after edge 4 of SEND -> next cycle clk_oe=data_oe=rx_inhibit=0. tx_ready=1 the first cycle after release.
//  T6 tx_valid with 8'hFF while busy is ignored (frame still carries 8'hED).
//     A 2-cycle low glitch on ps2_clk_i does not advance the edge count.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit path.
package ps2_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StInhibit,
      StReq,
      StSend,
      StAck,
      StWaitIdle
   } ps2_state_e;

   localparam logic [7:0]  PS2_CMD_SET_LEDS = 8'hED;
   localparam logic [7:0]  PS2_CMD_RESET    = 8'hFF;
   localparam logic [7:0]  PS2_RESP_ACK     = 8'hFA;
   localparam int unsigned PS2_FRAME_EDGES  = 11;

   // Odd parity: the bit that makes the total count of ones in data+parity odd.
   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises one raw PS/2 pin and debounces it; emits one-cycle fall/rise strobes
// when the filtered level changes.
module ps2_line_filter #(
   parameter int unsigned FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic fall,
   output logic rise
);

   localparam int unsigned CntW = $clog2(FILTER_LEN + 1);

   logic [1:0]      sync_q;
   logic            level_q, level_d;
   logic            fall_q, fall_d;
   logic            rise_q, rise_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   // A new level is accepted only after FILTER_LEN consecutive samples disagree with it.
   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      fall_d  = 1'b0;
      rise_d  = 1'b0;
      if (sync_q[1] == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CntW'(FILTER_LEN - 1)) begin
         level_d = sync_q[1];
         cnt_d   = '0;
         fall_d  = ~sync_q[1];
         rise_d  = sync_q[1];
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_q  <= 2'b11;
         level_q <= 1'b1;
         fall_q  <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= {sync_q[0], raw};
         level_q <= level_d;
         fall_q  <= fall_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign fall  = fall_q;
   assign rise  = rise_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: issues the host request sequence and clocks one
// command byte out to the device, reporting ack/timeout status with a done pulse.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = 10000,
   parameter int unsigned TIMEOUT_CYCLES = 1500000,
   parameter int unsigned FILTER_LEN     = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       clk_oe,
   output logic       data_oe,
   output logic       rx_inhibit,
   output logic       done,
   output logic       ack_err,
   output logic       timeout_err
);

   localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [3:0]  StopEdge = 4'(PS2_FRAME_EDGES - 1);

   logic clk_level, clk_fall, clk_rise;
   logic data_level, data_fall, data_rise;

   ps2_line_filter #(
      .FILTER_LEN(FILTER_LEN)
   ) u_clk_filter (
      .clk  (clk),
      .reset(reset),
      .raw  (ps2_clk_i),
      .level(clk_level),
      .fall (clk_fall),
      .rise (clk_rise)
   );

   ps2_line_filter #(
      .FILTER_LEN(FILTER_LEN)
   ) u_data_filter (
      .clk  (clk),
      .reset(reset),
      .raw  (ps2_data_i),
      .level(data_level),
      .fall (data_fall),
      .rise (data_rise)
   );

   logic unused_strobes;
   assign unused_strobes = ^{clk_rise, data_fall, data_rise};

   ps2_state_e      state_q, state_d;
   logic [8:0]      shift_q, shift_d;
   logic [3:0]      edge_cnt_q, edge_cnt_d;
   logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
   logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic            clk_oe_q, clk_oe_d;
   logic            data_oe_q, data_oe_d;
   logic            rx_inhibit_q, rx_inhibit_d;
   logic            done_q, done_d;
   logic            ack_err_q, ack_err_d;
   logic            timeout_err_q, timeout_err_d;
   logic            tx_ready_q, tx_ready_d;
   logic            tmo_expired;

   assign tmo_expired = (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d       = state_q;
      shift_d       = shift_q;
      edge_cnt_d    = edge_cnt_q;
      inh_cnt_d     = inh_cnt_q;
      tmo_cnt_d     = tmo_cnt_q;
      clk_oe_d      = clk_oe_q;
      data_oe_d     = data_oe_q;
      rx_inhibit_d  = rx_inhibit_q;
      ack_err_d     = ack_err_q;
      timeout_err_d = timeout_err_q;
      done_d        = 1'b0;
      tx_ready_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            tx_ready_d = 1'b1;
            if (tx_valid && tx_ready_q) begin
               shift_d       = {odd_parity(tx_data), tx_data};
               rx_inhibit_d  = 1'b1;
               clk_oe_d      = 1'b1;
               data_oe_d     = 1'b0;
               ack_err_d     = 1'b0;
               timeout_err_d = 1'b0;
               inh_cnt_d     = '0;
               tx_ready_d    = 1'b0;
               state_d       = StInhibit;
            end
         end

         StInhibit: begin
            inh_cnt_d = inh_cnt_q + 1'b1;
            // Start bit goes low during the final cycle that the clock is still held.
            if (32'(inh_cnt_q) + 32'd2 >= INHIBIT_CYCLES) begin
               data_oe_d = 1'b1;
            end
            if (inh_cnt_q == InhW'(INHIBIT_CYCLES - 1)) begin
               clk_oe_d   = 1'b0;
               tmo_cnt_d  = '0;
               edge_cnt_d = '0;
               state_d    = StReq;
            end
         end

         StReq, StSend, StAck: begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            if (clk_fall) begin
               edge_cnt_d = edge_cnt_q + 1'b1;
               if (state_q == StAck) begin
                  ack_err_d = data_level;
                  state_d   = StWaitIdle;
               end else if (edge_cnt_q == StopEdge - 4'd1) begin
                  data_oe_d = 1'b0;
                  state_d   = StAck;
               end else begin
                  data_oe_d = ~shift_q[0];
                  shift_d   = {1'b0, shift_q[8:1]};
                  state_d   = StSend;
               end
            end else if (tmo_expired) begin
               clk_oe_d      = 1'b0;
               data_oe_d     = 1'b0;
               done_d        = 1'b1;
               timeout_err_d = 1'b1;
               ack_err_d     = 1'b0;
               rx_inhibit_d  = 1'b0;
               state_d       = StIdle;
            end
         end

         StWaitIdle: begin
            if (clk_level && data_level) begin
               done_d       = 1'b1;
               rx_inhibit_d = 1'b0;
               state_d      = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= StIdle;
         shift_q       <= '0;
         edge_cnt_q    <= '0;
         inh_cnt_q     <= '0;
         tmo_cnt_q     <= '0;
         clk_oe_q      <= 1'b0;
         data_oe_q     <= 1'b0;
         rx_inhibit_q  <= 1'b0;
         done_q        <= 1'b0;
         ack_err_q     <= 1'b0;
         timeout_err_q <= 1'b0;
         tx_ready_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         shift_q       <= shift_d;
         edge_cnt_q    <= edge_cnt_d;
         inh_cnt_q     <= inh_cnt_d;
         tmo_cnt_q     <= tmo_cnt_d;
         clk_oe_q      <= clk_oe_d;
         data_oe_q     <= data_oe_d;
         rx_inhibit_q  <= rx_inhibit_d;
         done_q        <= done_d;
         ack_err_q     <= ack_err_d;
         timeout_err_q <= timeout_err_d;
         tx_ready_q    <= tx_ready_d;
      end
   end

   assign tx_ready    = tx_ready_q;
   assign clk_oe      = clk_oe_q;
   assign data_oe     = data_oe_q;
   assign rx_inhibit  = rx_inhibit_q;
   assign done        = done_q;
   assign ack_err     = ack_err_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device, randomized commands, and a
// scoreboard that checks every done pulse against the expected frame and flags.
`timescale 1ns/1ps
module tb_ps2_host_tx;

   localparam int INH  = 20;
   localparam int TMO  = 5000;
   localparam int HALF = 200;

   logic       clk = 1'b0;
   logic       reset;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready, clk_oe, data_oe, rx_inhibit, done, ack_err, timeout_err;
   logic       dev_clk_low, dev_data_low, glitch_low;
   logic       ps2_clk_i, ps2_data_i;

   assign ps2_clk_i  = ~(clk_oe | dev_clk_low | glitch_low);
   assign ps2_data_i = ~(data_oe | dev_data_low);

   always #5 clk = ~clk;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TMO),
      .FILTER_LEN    (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .ps2_clk_i  (ps2_clk_i),
      .ps2_data_i (ps2_data_i),
      .clk_oe     (clk_oe),
      .data_oe    (data_oe),
      .rx_inhibit (rx_inhibit),
      .done       (done),
      .ack_err    (ack_err),
      .timeout_err(timeout_err)
   );

   typedef struct packed {
      logic [10:0] frame;
      logic        ack;
      logic        tmo;
   } exp_t;

   exp_t        exp_q[$];
   int          vectors = 0;
   int          errors  = 0;
   int          dev_mode;   // 0 = ack, 1 = no ack, 2 = never clocks
   bit          glitch_en;
   int          dev_fall_cnt;
   logic [10:0] dev_frame;
   logic        prev_inhibit = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Frame as the device sees it on rising edges: start, D0..D7, odd parity, stop.
   function automatic logic [10:0] ref_frame(input logic [7:0] b);
      int   ones = 0;
      logic par;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      par = (ones % 2 == 0);
      return {1'b1, par, b, 1'b0};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic dev_step();
      @(posedge clk);
      #2;
   endtask

   // Device model
   initial begin
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      glitch_low   = 1'b0;
      dev_fall_cnt = 0;
      dev_frame    = '0;
      forever begin
         dev_step();
         if (reset && !clk_oe && data_oe && rx_inhibit) begin
            dev_fall_cnt = 0;
            dev_frame    = '0;
            if (dev_mode == 2) begin
               while (rx_inhibit) dev_step();
            end else begin
               repeat (HALF) dev_step();
               dev_frame[0] = ps2_data_i;
               for (int i = 1; i <= 11; i++) begin
                  if (!rx_inhibit) break;
                  dev_clk_low  = 1'b1;
                  dev_fall_cnt = i;
                  repeat (HALF) dev_step();
                  dev_clk_low = 1'b0;
                  if (i <= 10) dev_frame[i] = ps2_data_i;
                  if (i == 10 && dev_mode == 0) dev_data_low = 1'b1;
                  if (i == 11) dev_data_low = 1'b0;
                  if (glitch_en && i == 3) begin
                     repeat (HALF / 2) dev_step();
                     glitch_low = 1'b1;
                     repeat (2) dev_step();
                     glitch_low = 1'b0;
                     repeat (HALF / 2 - 2) dev_step();
                  end else begin
                     repeat (HALF) dev_step();
                  end
               end
               dev_clk_low  = 1'b0;
               dev_data_low = 1'b0;
            end
         end
      end
   end

   // Scoreboard monitor
   always @(negedge clk) begin
      if (reset && done) begin
         if (exp_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_done: got a done pulse, expected none");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("ack_err", ack_err, e.ack);
            check("timeout_err", timeout_err, e.tmo);
            if (!e.tmo) check("frame_bits", dev_frame, e.frame);
            check("lines_at_done", {clk_oe, data_oe, rx_inhibit}, 3'b000);
            check("inhibit_before_done", prev_inhibit, 1'b1);
         end
      end
      prev_inhibit = rx_inhibit;
   end

   task automatic send(input logic [7:0] b, input int mode, input bit glitch,
                       input bit poke, input int abort_edge);
      int   n;
      int   hi;
      int   first_d;
      exp_t e;
      dev_mode  = mode;
      glitch_en = glitch;
      n = 0;
      while (!tx_ready && n < 1000) begin
         step();
         n++;
      end
      check("tx_ready_before_send", tx_ready, 1'b1);
      if (abort_edge == 0) begin
         e.frame = ref_frame(b);
         e.ack   = (mode == 1);
         e.tmo   = (mode == 2);
         exp_q.push_back(e);
      end
      tx_valid = 1'b1;
      tx_data  = b;
      step();
      tx_valid = 1'b0;
      check("clk_oe_after_accept", clk_oe, 1'b1);
      if (poke) begin
         tx_valid = 1'b1;
         tx_data  = 8'hFF;
      end
      hi      = 0;
      first_d = -1;
      while (clk_oe && hi < 1000) begin
         hi++;
         if (data_oe && first_d < 0) first_d = hi;
         step();
      end
      tx_valid = 1'b0;
      check("inhibit_len", hi, INH);
      check("start_bit_cycle", first_d, INH);

      if (abort_edge > 0) begin
         n = 0;
         while (dev_fall_cnt < abort_edge && n < 10000) begin
            step();
            n++;
         end
         check("reached_abort_edge", dev_fall_cnt, abort_edge);
         repeat (20) step();
         reset = 1'b0;
         step();
         check("lines_after_reset", {clk_oe, data_oe, rx_inhibit}, 3'b000);
         check("tx_ready_in_reset", tx_ready, 1'b0);
         repeat (2) step();
         reset = 1'b1;
         step();
         check("tx_ready_after_release", tx_ready, 1'b1);
         repeat (600) step();
         return;
      end

      n = 0;
      while (!done && n < 20000) begin
         n++;
         step();
      end
      if (mode == 2) check("timeout_cycles", n, TMO);
      else check("done_seen", done, 1'b1);
      step();
      check("done_one_cycle", done, 1'b0);
      check("tx_ready_after_done", tx_ready, 1'b1);
      repeat (300) step();
   endtask

   initial begin
      reset    = 1'b0;
      tx_valid = 1'b0;
      tx_data  = '0;
      dev_mode  = 0;
      glitch_en = 1'b0;
      repeat (3) step();
      check("reset_outputs",
            {clk_oe, data_oe, rx_inhibit, done, ack_err, timeout_err, tx_ready}, 7'b0);
      reset = 1'b1;
      step();
      check("tx_ready_first_cycle", tx_ready, 1'b1);

      send(8'hED, 0, 1'b0, 1'b0, 0);      // T1
      send(8'h07, 0, 1'b0, 1'b0, 0);      // T2
      send(8'h5A, 1, 1'b0, 1'b0, 0);      // T3 no ack
      send(8'hFF, 2, 1'b0, 1'b0, 0);      // T4 timeout
      send(8'hED, 0, 1'b0, 1'b0, 4);      // T5 reset mid-frame
      send(8'hED, 0, 1'b1, 1'b1, 0);      // T6 busy poke + clock glitch
      for (int k = 0; k < 6; k++) begin
         send(8'($urandom), int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 0);
      end

      check("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #(900_000);
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
